// File: rtl/soc_system_ocm_pkg.sv
// Shared definitions for the parametrised on-chip block buffer: lane sizing,
// address-width helper, read-latency encoding and parameter-legality checks.
package soc_system_ocm_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      RD_LAT_1 = 2'd1,
      RD_LAT_2 = 2'd2
   } rd_lat_e;

   // Smallest r such that 2**r >= value.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((32'sd1 <<< r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Number of byte lanes in a word.
   function automatic int lanes_of(input int data_w);
      return data_w / BYTE_W;
   endfunction

   function automatic bit is_pow2_min2(input int value);
      return (value >= 2) && ((value & (value - 1)) == 0);
   endfunction

   function automatic bit latency_ok(input int lat);
      return (lat == int'(RD_LAT_1)) || (lat == int'(RD_LAT_2));
   endfunction

endpackage

`ifndef SOC_OCM_PARAM_CHECK
`define SOC_OCM_PARAM_CHECK(lbl, cond, msg) if (!(cond)) begin : lbl $error(msg); end
`endif

// File: rtl/soc_system_ocm_dualport_v2_if.sv
// One Avalon-MM slave port of the block buffer (address, select, strobes,
// byte lanes, data and read-valid).
interface soc_system_ocm_dualport_v2_if #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 128
);
   localparam int BE_W = DATA_W / 8;

   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              read;
   logic              write;
   logic [BE_W-1:0]   byteenable;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output address, chipselect, read, write, byteenable, writedata,
      input  readdata, readdatavalid
   );

   modport slave (
      input  address, chipselect, read, write, byteenable, writedata,
      output readdata, readdatavalid
   );
endinterface

// File: rtl/soc_system_ocm_rd_pipe.sv
// Read-return pipeline: READ_LATENCY register stages carrying data and valid.
// Data stages only load when the stage feeding them is valid, so the final
// data register holds its last value between pulses. Reset clears every stage,
// discarding any read in flight.
module soc_system_ocm_rd_pipe
   import soc_system_ocm_pkg::*;
#(
   parameter int DATA_W       = 128,
   parameter int READ_LATENCY = int'(RD_LAT_1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   logic [READ_LATENCY-1:0] vld_r;
   logic [DATA_W-1:0]       dat_r [READ_LATENCY];

   // Shift valid every cycle; advance data only behind a valid stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_r <= '0;
         for (int s = 0; s < READ_LATENCY; s++) begin
            dat_r[s] <= '0;
         end
      end else begin
         vld_r[0] <= in_valid;
         if (in_valid) begin
            dat_r[0] <= in_data;
         end
         for (int s = 1; s < READ_LATENCY; s++) begin
            vld_r[s] <= vld_r[s-1];
            if (vld_r[s-1]) begin
               dat_r[s] <= dat_r[s-1];
            end
         end
      end
   end

   assign out_valid = vld_r[READ_LATENCY-1];
   assign out_data  = dat_r[READ_LATENCY-1];

endmodule

// File: rtl/soc_system_ocm_dualport_v2.sv
// True dual-port, byte-enabled block buffer shared by the HPS bridge (s1) and
// the AES core (s2). Same-address accesses in one cycle are resolved by a
// per-lane merge (port 1 beats port 2), and reads return the merged word.
// word_valid tracks which words port 1 has written completely.
module soc_system_ocm_dualport_v2
   import soc_system_ocm_pkg::*;
#(
   parameter int DATA_W        = 128,
   parameter int DEPTH         = 4,
   parameter int ADDR_W        = 2,
   parameter int READ_LATENCY  = 1,
   parameter int CLEAR_ON_READ = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   soc_system_ocm_dualport_v2_if.slave   s1,
   soc_system_ocm_dualport_v2_if.slave   s2,
   output logic [DEPTH-1:0]              word_valid
);

   localparam int LANES = lanes_of(DATA_W);

   `SOC_OCM_PARAM_CHECK(g_chk_width, (DATA_W % BYTE_W) == 0 && DATA_W > 0, "DATA_W must be a positive multiple of 8")
   `SOC_OCM_PARAM_CHECK(g_chk_depth, is_pow2_min2(DEPTH), "DEPTH must be a power of 2 and at least 2")
   `SOC_OCM_PARAM_CHECK(g_chk_addr, ADDR_W == clog2(DEPTH), "ADDR_W must equal log2(DEPTH)")
   `SOC_OCM_PARAM_CHECK(g_chk_lat, latency_ok(READ_LATENCY), "READ_LATENCY must be 1 or 2")

   logic              we1_s;
   logic              re1_s;
   logic              we2_s;
   logic              re2_s;
   logic [DATA_W-1:0] rd_word1_s;
   logic [DATA_W-1:0] rd_word2_s;
   logic [DEPTH-1:0]  set_s;
   logic [DEPTH-1:0]  clr_s;
   logic [DEPTH-1:0]  word_valid_r;
   logic [DATA_W-1:0] mem_r [DEPTH];

   // Request qualification: a write always beats a simultaneous read.
   always_comb begin
      we1_s = s1.chipselect & s1.write;
      re1_s = s1.chipselect & s1.read & ~s1.write;
      we2_s = s2.chipselect & s2.write;
      re2_s = s2.chipselect & s2.read & ~s2.write;
   end

   // Post-write view of each port's addressed word: the value written back on a
   // write and the value returned on a read-during-write.
   always_comb begin
      rd_word1_s = mem_r[s1.address];
      rd_word2_s = mem_r[s2.address];
      for (int i = 0; i < LANES; i++) begin
         if (we1_s && s1.byteenable[i]) begin
            rd_word1_s[i*BYTE_W +: BYTE_W] = s1.writedata[i*BYTE_W +: BYTE_W];
         end else if (we2_s && s2.byteenable[i] && (s2.address == s1.address)) begin
            rd_word1_s[i*BYTE_W +: BYTE_W] = s2.writedata[i*BYTE_W +: BYTE_W];
         end else begin
            rd_word1_s[i*BYTE_W +: BYTE_W] = mem_r[s1.address][i*BYTE_W +: BYTE_W];
         end

         if (we1_s && s1.byteenable[i] && (s1.address == s2.address)) begin
            rd_word2_s[i*BYTE_W +: BYTE_W] = s1.writedata[i*BYTE_W +: BYTE_W];
         end else if (we2_s && s2.byteenable[i]) begin
            rd_word2_s[i*BYTE_W +: BYTE_W] = s2.writedata[i*BYTE_W +: BYTE_W];
         end else begin
            rd_word2_s[i*BYTE_W +: BYTE_W] = mem_r[s2.address][i*BYTE_W +: BYTE_W];
         end
      end
   end

   // Storage update; on a same-address collision both ports store the identical merged word.
   always_ff @(posedge clk) begin
      if (we2_s) begin
         mem_r[s2.address] <= rd_word2_s;
      end
      if (we1_s) begin
         mem_r[s1.address] <= rd_word1_s;
      end
   end

   // Fill-bitmap set/clear masks for this cycle.
   always_comb begin
      set_s = '0;
      clr_s = '0;
      if (we1_s && (&s1.byteenable)) begin
         set_s[s1.address] = 1'b1;
      end else begin
         set_s[s1.address] = 1'b0;
      end
      if (re2_s && (CLEAR_ON_READ != 0)) begin
         clr_s[s2.address] = 1'b1;
      end else begin
         clr_s[s2.address] = 1'b0;
      end
   end

   // Fill bitmap register; a set in the same cycle as a clear wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_valid_r <= '0;
      end else begin
         word_valid_r <= (word_valid_r & ~clr_s) | set_s;
      end
   end

   assign word_valid = word_valid_r;

   soc_system_ocm_rd_pipe #(
      .DATA_W       (DATA_W),
      .READ_LATENCY (READ_LATENCY)
   ) u_rd_pipe1 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (re1_s),
      .in_data   (rd_word1_s),
      .out_valid (s1.readdatavalid),
      .out_data  (s1.readdata)
   );

   soc_system_ocm_rd_pipe #(
      .DATA_W       (DATA_W),
      .READ_LATENCY (READ_LATENCY)
   ) u_rd_pipe2 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (re2_s),
      .in_data   (rd_word2_s),
      .out_valid (s2.readdatavalid),
      .out_data  (s2.readdata)
   );

endmodule
